// File: rtl/vpd_responder.sv
// vpd_responder: configuration-space VPD access responder.
// Serves a writable word RAM, two read-only ID words and a lock bit behind a
// held-request / done-pulse handshake with a fixed two-cycle latency.
module vpd_responder #(
  parameter int          VPD_WORDS = 256,
  parameter logic [31:0] VPD_ID0   = 32'h4F43_5644,
  parameter logic [31:0] VPD_ID1   = 32'h0000_0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] cfg_vpd_addr,
  input  logic        cfg_vpd_wren,
  input  logic [31:0] cfg_vpd_wdata,
  input  logic        cfg_vpd_rden,
  output logic [31:0] vpd_cfg_rdata,
  output logic        vpd_cfg_done,
  output logic        vpd_err_unimplemented_addr,
  output logic        vpd_err_protocol
);

  localparam int          IDX       = (VPD_WORDS > 1) ? $clog2(VPD_WORDS) : 1;
  localparam logic [14:0] ADDR_ID0  = 15'h7F00;
  localparam logic [14:0] ADDR_ID1  = 15'h7F01;
  localparam logic [14:0] ADDR_LOCK = 15'h7F02;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t      state_q, state_d;

  // Captured request (data side carries no reset; control flags do).
  logic [14:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q, rd_q, proto_q;
  logic        lock_q;

  logic [31:0] mem [VPD_WORDS];
  logic [31:0] ram_rd_q;

  logic        accept;
  logic        ram_we, ram_re, lock_we;
  logic        hit_ram, hit_id0, hit_id1, hit_lock, unimpl;
  logic [31:0] rd_mux;

  // Full 15-bit decode of the captured address; nothing aliases.
  always_comb begin
    hit_ram  = ({17'd0, addr_q} < 32'(VPD_WORDS));
    hit_id0  = (addr_q == ADDR_ID0);
    hit_id1  = (addr_q == ADDR_ID1);
    hit_lock = (addr_q == ADDR_LOCK);
    unimpl   = !(hit_ram || hit_id0 || hit_id1 || hit_lock);
    rd_mux   = 32'd0;
    if (hit_ram)       rd_mux = ram_rd_q;
    else if (hit_id0)  rd_mux = VPD_ID0;
    else if (hit_id1)  rd_mux = VPD_ID1;
    else if (hit_lock) rd_mux = {31'd0, lock_q};
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and output decode; outputs are zero outside the DONE cycle.
  always_comb begin
    state_d                    = state_q;
    accept                     = 1'b0;
    ram_we                     = 1'b0;
    ram_re                     = 1'b0;
    lock_we                    = 1'b0;
    vpd_cfg_done               = 1'b0;
    vpd_cfg_rdata              = 32'd0;
    vpd_err_unimplemented_addr = 1'b0;
    vpd_err_protocol           = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_vpd_rden || cfg_vpd_wren) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!proto_q && wr_q) begin
          ram_we  = hit_ram && !lock_q;
          lock_we = hit_lock;
        end
        if (!proto_q && rd_q && hit_ram) ram_re = 1'b1;
      end
      DONE: begin
        vpd_cfg_done = 1'b1;
        state_d      = RELEASE;
        if (proto_q) begin
          vpd_err_protocol = 1'b1;
        end else begin
          vpd_err_unimplemented_addr = unimpl;
          if (rd_q) vpd_cfg_rdata = rd_mux;
        end
      end
      RELEASE: begin
        // Wait for the requester to drop both strobes so a held request
        // is not executed twice.
        if (!cfg_vpd_rden && !cfg_vpd_wren) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture address and write data at acceptance.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q  <= cfg_vpd_addr;
      wdata_q <= cfg_vpd_wdata;
    end
  end

  // Capture operation type at acceptance; both strobes set marks a protocol error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      proto_q <= 1'b0;
    end else if (accept) begin
      wr_q    <= cfg_vpd_wren;
      rd_q    <= cfg_vpd_rden;
      proto_q <= cfg_vpd_wren && cfg_vpd_rden;
    end
  end

  // Lock bit: comes out of reset locked, writable only through its own address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        lock_q <= 1'b1;
    else if (lock_we) lock_q <= wdata_q[0];
  end

  // Single-port RAM, one-cycle read latency, contents survive reset.
  always_ff @(posedge clock) begin
    if (ram_we) mem[addr_q[IDX-1:0]] <= wdata_q;
    if (ram_re) ram_rd_q <= mem[addr_q[IDX-1:0]];
  end

endmodule

// File: tb/tb_vpd_responder.sv
// tb_vpd_responder: directed scenarios plus randomized traffic against a
// behavioural model of the VPD address map, lock and handshake timing.
module tb_vpd_responder;

  localparam int          VPD_WORDS = 256;
  localparam logic [31:0] ID0       = 32'h4F43_5644;
  localparam logic [31:0] ID1       = 32'h0000_0001;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] cfg_vpd_addr = '0;
  logic        cfg_vpd_wren = 1'b0;
  logic [31:0] cfg_vpd_wdata = '0;
  logic        cfg_vpd_rden = 1'b0;
  logic [31:0] vpd_cfg_rdata;
  logic        vpd_cfg_done;
  logic        vpd_err_unimplemented_addr;
  logic        vpd_err_protocol;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_mem   [VPD_WORDS];
  bit          m_known [VPD_WORDS];
  bit          m_lock;

  vpd_responder #(
    .VPD_WORDS (VPD_WORDS),
    .VPD_ID0   (ID0),
    .VPD_ID1   (ID1)
  ) dut (
    .clock                      (clock),
    .reset                      (reset),
    .cfg_vpd_addr               (cfg_vpd_addr),
    .cfg_vpd_wren               (cfg_vpd_wren),
    .cfg_vpd_wdata              (cfg_vpd_wdata),
    .cfg_vpd_rden               (cfg_vpd_rden),
    .vpd_cfg_rdata              (vpd_cfg_rdata),
    .vpd_cfg_done               (vpd_cfg_done),
    .vpd_err_unimplemented_addr (vpd_err_unimplemented_addr),
    .vpd_err_protocol           (vpd_err_protocol)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_ram(input logic [14:0] a);
    return int'(a) < VPD_WORDS;
  endfunction

  function automatic bit is_impl(input logic [14:0] a);
    return is_ram(a) || a == 15'h7F00 || a == 15'h7F01 || a == 15'h7F02;
  endfunction

  // One complete request: drive, expect done exactly 2 cycles later, hold the
  // strobes for 1+hold more cycles (no second done), then drop for one cycle.
  task automatic issue(input logic [14:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd, input int hold);
    logic [31:0] exp_rd;
    bit          exp_u, exp_p, data_known;
    int          lat, extra;
    exp_p      = rd && wr;
    exp_u      = !exp_p && !is_impl(a);
    exp_rd     = 32'd0;
    data_known = 1'b1;
    if (rd && !exp_p) begin
      if (is_ram(a)) begin
        exp_rd     = m_mem[int'(a)];
        data_known = m_known[int'(a)];
      end else if (a == 15'h7F00) exp_rd = ID0;
      else if (a == 15'h7F01)     exp_rd = ID1;
      else if (a == 15'h7F02)     exp_rd = {31'd0, m_lock};
    end
    cfg_vpd_addr  = a;
    cfg_vpd_rden  = rd;
    cfg_vpd_wren  = wr;
    cfg_vpd_wdata = wd;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock); #1;
      if (vpd_cfg_done) begin
        lat = k;
        break;
      end
      chk("rdata_idle", vpd_cfg_rdata, 32'd0);
    end
    chk("latency", 32'(lat), 32'd2);
    if (lat != 0) begin
      if (data_known) chk("rdata", vpd_cfg_rdata, exp_rd);
      chk("err_unimpl", {31'd0, vpd_err_unimplemented_addr}, {31'd0, exp_u});
      chk("err_proto", {31'd0, vpd_err_protocol}, {31'd0, exp_p});
    end
    extra = 0;
    for (int k = 0; k < hold + 1; k++) begin
      @(posedge clock); #1;
      if (vpd_cfg_done) extra++;
    end
    chk("redone", 32'(extra), 32'd0);
    chk("rdata_after", vpd_cfg_rdata, 32'd0);
    cfg_vpd_rden = 1'b0;
    cfg_vpd_wren = 1'b0;
    @(posedge clock); #1;
    if (wr && !exp_p) begin
      if (is_ram(a) && !m_lock) begin
        m_mem[int'(a)]   = wd;
        m_known[int'(a)] = 1'b1;
      end
      if (a == 15'h7F02) m_lock = wd[0];
    end
  endtask

  task automatic rd_req(input logic [14:0] a);
    issue(a, 1'b1, 1'b0, 32'd0, 0);
  endtask

  task automatic wr_req(input logic [14:0] a, input logic [31:0] d);
    issue(a, 1'b0, 1'b1, d, 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_done"}, {31'd0, vpd_cfg_done}, 32'd0);
    chk({tag, "_rdata"}, vpd_cfg_rdata, 32'd0);
    chk({tag, "_uerr"}, {31'd0, vpd_err_unimplemented_addr}, 32'd0);
    chk({tag, "_perr"}, {31'd0, vpd_err_protocol}, 32'd0);
  endtask

  initial begin
    logic [14:0] a;
    logic [31:0] d;
    int          sel, op, dcnt;

    for (int i = 0; i < VPD_WORDS; i++) m_known[i] = 1'b0;
    m_lock = 1'b1;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check_quiet("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // Locked after reset; a RAM write is dropped.
    rd_req(15'h7F02);
    wr_req(15'h0005, 32'h1234_5678);
    rd_req(15'h0005);

    // Unlock, write, read back, ID read.
    wr_req(15'h7F02, 32'h0000_0000);
    wr_req(15'h0005, 32'hDEAD_BEEF);
    rd_req(15'h0005);
    rd_req(15'h7F00);
    rd_req(15'h7F02);

    // Unimplemented and read-only addresses.
    rd_req(15'h0100);
    wr_req(15'h0100, 32'hFFFF_FFFF);
    rd_req(15'h7F03);
    rd_req(15'h7FFF);
    rd_req(15'h4005);
    wr_req(15'h7F00, 32'h0BAD_0BAD);
    rd_req(15'h7F00);
    wr_req(15'h7F01, 32'h0BAD_0BAD);
    rd_req(15'h7F01);
    wr_req(15'h00FF, 32'hA5A5_00FF);
    rd_req(15'h00FF);

    // Both strobes together.
    issue(15'h0005, 1'b1, 1'b1, 32'h0000_0000, 0);
    rd_req(15'h0005);

    // Long hold after done, then a new request after a one-cycle drop.
    issue(15'h0005, 1'b1, 1'b0, 32'd0, 10);
    rd_req(15'h0005);

    // Reset during the ACCESS cycle of a write.
    wr_req(15'h0006, 32'h0600_0006);
    cfg_vpd_addr  = 15'h0006;
    cfg_vpd_wdata = 32'hBAD0_0006;
    cfg_vpd_wren  = 1'b1;
    @(posedge clock); #1;
    reset        = 1'b1;
    cfg_vpd_wren = 1'b0;
    #1;
    check_quiet("async_rst");
    m_lock = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      if (vpd_cfg_done) dcnt++;
      if (k == 1) reset = 1'b0;
    end
    chk("rst_nodone", 32'(dcnt), 32'd0);
    rd_req(15'h0006);
    rd_req(15'h7F02);

    // RAM survives reset and lock is back on.
    wr_req(15'h0005, 32'h1234_5678);
    rd_req(15'h0005);

    // Request already high when reset releases.
    reset = 1'b1;
    cfg_vpd_addr = 15'h7F01;
    cfg_vpd_rden = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    issue(15'h7F01, 1'b1, 1'b0, 32'd0, 0);

    // Randomized traffic.
    wr_req(15'h7F02, 32'h0000_0000);
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 2)      a = 15'($urandom_range(0, 15));
      else if (sel <= 4) a = 15'($urandom_range(0, VPD_WORDS - 1));
      else if (sel == 5) a = 15'h7F00;
      else if (sel == 6) a = 15'h7F01;
      else if (sel == 7) a = (($urandom_range(0, 3) == 0) ? 15'h7F02 : 15'($urandom_range(0, 15)));
      else if (sel == 8) a = 15'($urandom_range(VPD_WORDS, 16'h7EFF));
      else               a = 15'($urandom_range(16'h7F03, 16'h7FFF));
      d  = $urandom;
      op = $urandom_range(0, 9);
      if (op < 5)      issue(a, 1'b1, 1'b0, d, $urandom_range(0, 2));
      else if (op < 9) issue(a, 1'b0, 1'b1, d, $urandom_range(0, 2));
      else             issue(a, 1'b1, 1'b1, d, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vpd_responder.md
VPD_RESPONDER -- requirements
Module: vpd_responder

Interface
REQ-001 SHALL have parameter VPD_WORDS, default 256, number of 32-bit writable VPD words at word addresses 0x0000..VPD_WORDS-1 (power of 2, max 4096).
REQ-002 SHALL have parameter VPD_ID0, default 32'h4F43_5644, read-only ID word at address 0x7F00.
REQ-003 SHALL have parameter VPD_ID1, default 32'h0000_0001, read-only version word at address 0x7F01.
REQ-004 SHALL have port clock, input, 1, single clock for all logic.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port cfg_vpd_addr, input, 15, word address; stable while rden or wren is held.
REQ-007 SHALL have port cfg_vpd_wren, input, 1, write request; held at 1 until vpd_cfg_done is seen.
REQ-008 SHALL have port cfg_vpd_wdata, input, 32, write data; valid while wren=1.
REQ-009 SHALL have port cfg_vpd_rden, input, 1, read request; held at 1 until vpd_cfg_done is seen.
REQ-010 SHALL have port vpd_cfg_rdata, output, 32, read data; valid in the done cycle of a read.
REQ-011 SHALL have port vpd_cfg_done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port vpd_err_unimplemented_addr, output, 1, one-cycle pulse, coincident with done, for an unimplemented address.
REQ-013 SHALL have port vpd_err_protocol, output, 1, one-cycle pulse, coincident with done, when rden and wren are both 1 at acceptance.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, DONE, RELEASE.
REQ-015 IDLE: on rden|wren=1, capture addr/wdata/op and go to ACCESS (acceptance cycle N).
REQ-016 ACCESS: perform RAM write or issue RAM/register read; go to DONE next cycle.
REQ-017 DONE: drive vpd_cfg_done=1 for exactly one cycle (cycle N+2); go to RELEASE.
REQ-018 RELEASE: remain until rden=0 and wren=0 are sampled together; then go to IDLE. A request held high after done SHALL NOT be re-executed.
REQ-019 Address map: 0x0000..VPD_WORDS-1 is the RAM (R/W). 0x7F00 = VPD_ID0 (RO). 0x7F01 = VPD_ID1 (RO). 0x7F02 = LOCK (R/W, bit0 only, other bits read 0). All other addresses are unimplemented.
REQ-020 A RAM write SHALL occur only when LOCK[0]=0; when locked, the write is dropped silently and done still pulses with no error.
REQ-021 Writes to ID addresses SHALL be ignored and done SHALL pulse with no error.
REQ-022 An unimplemented read SHALL return rdata=0, pulse done and pulse vpd_err_unimplemented_addr. An unimplemented write has no side effect and gives the same pulses.
REQ-023 If both rden and wren are 1 at acceptance: no write, rdata=0, pulse done and vpd_err_protocol; vpd_err_unimplemented_addr=0.
REQ-024 vpd_cfg_rdata SHALL equal 0 in every cycle except the done cycle of a read.
REQ-025 RAM SHALL be a single-port synchronous array with 1-cycle read latency; contents are not reset. Address decode compares the full 15 bits with no aliasing.
REQ-026 Fixed latency: done SHALL occur exactly 2 cycles after acceptance for every request type.

Reset
REQ-027 While reset=1, the following SHALL hold asynchronously: FSM=IDLE, vpd_cfg_done=0, vpd_cfg_rdata=0, both error outputs=0, LOCK[0]=1.
REQ-028 If reset asserts mid-transaction, the pending operation SHALL be aborted; no done pulse occurs for it; a write in ACCESS during reset SHALL NOT commit.
REQ-029 After reset deasserts with rden or wren already high, that request SHALL be accepted normally from IDLE.

Verification
REQ-030 Reset, read 0x7F02 -> rdata=0x00000001, done at N+2; write 0x0005=0x12345678, then read 0x0005 -> data unchanged from its previous contents (locked).
REQ-031 Write 0x7F02=0, write 0x0005=0xDEADBEEF, read 0x0005 -> rdata=0xDEADBEEF; read 0x7F00 -> rdata=0x4F435644.
REQ-032 Read 0x0100 (VPD_WORDS=256) -> rdata=0, vpd_err_unimplemented_addr=1 coincident with the done pulse; write 0x7F00 -> done pulses with no error, and a readback still returns the ID.
REQ-033 Assert rden and wren together at 0x0005 -> vpd_err_protocol pulse, RAM word unchanged.
REQ-034 Hold rden for 10 cycles after done -> exactly one done pulse; the next request is accepted only after rden drops for at least 1 cycle.
REQ-035 Assert reset in the ACCESS cycle of a write to 0x0006 -> no done pulse, word 0x0006 unchanged, LOCK reads 1 after reset.
